// File: rtl/cpu_pkg.sv
// Shared constants for the 16-bit pipelined core: datapath widths and ALU operation encodings
// used by decode and execute.
package cpu_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned REG_W   = 3;
    localparam int unsigned ALUOP_W = 5;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_ADD   = 5'h00,
        ALU_SUB   = 5'h01,
        ALU_AND   = 5'h02,
        ALU_OR    = 5'h03,
        ALU_XOR   = 5'h04,
        ALU_SLL   = 5'h05,
        ALU_SRL   = 5'h06,
        ALU_SRA   = 5'h07,
        ALU_SLT   = 5'h08,
        ALU_SLTU  = 5'h09,
        ALU_PASSB = 5'h0A
    } alu_op_e;

    localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags a decode instruction that reads the register
// being loaded by the instruction currently in EX. Purely combinational.
module load_use_detect #(
    parameter int unsigned REG_W = cpu_pkg::REG_W
) (
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_read1regsel_i,
    input  logic [REG_W-1:0] id_read2regsel_i,
    input  logic             id_use1_i,
    input  logic             id_use2_i,
    input  logic             ex_valid_i,
    input  logic             ex_memread_i,
    input  logic             ex_regwrite_i,
    input  logic [REG_W-1:0] ex_writeregsel_i,
    output logic             hazard_o
);

    logic src1_match;
    logic src2_match;
    logic ex_is_load;

    // Register 0 is an ordinary register, so selector matches are never suppressed.
    assign src1_match = id_use1_i & (id_read1regsel_i == ex_writeregsel_i);
    assign src2_match = id_use2_i & (id_read2regsel_i == ex_writeregsel_i);
    assign ex_is_load = ex_valid_i & ex_memread_i & ex_regwrite_i;

    assign hazard_o = id_valid_i & ex_is_load & (src1_match | src2_match);

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with load-use bubble insertion, hold and flush.
// Optional macro ID_EX_STALL_CNT_EN adds a saturating bubble counter on port stall_cnt.
module id_ex_stage #(
    parameter int unsigned DATA_W  = cpu_pkg::DATA_W,
    parameter int unsigned REG_W   = cpu_pkg::REG_W,
    parameter int unsigned ALUOP_W = cpu_pkg::ALUOP_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [REG_W-1:0]   id_read1regsel,
    input  logic [REG_W-1:0]   id_read2regsel,
    input  logic               id_use1,
    input  logic               id_use2,
    input  logic [DATA_W-1:0]  id_read1data,
    input  logic [DATA_W-1:0]  id_read2data,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic [DATA_W-1:0]  id_pc,
    input  logic [REG_W-1:0]   id_writeregsel,
    input  logic               id_regwrite,
    input  logic               id_memread,
    input  logic               id_memwrite,
    input  logic [ALUOP_W-1:0] id_aluop,
    input  logic               ex_hold,
    input  logic               flush,
    output logic               id_stall,
    output logic               ex_valid,
    output logic [DATA_W-1:0]  ex_read1data,
    output logic [DATA_W-1:0]  ex_read2data,
    output logic [DATA_W-1:0]  ex_imm,
    output logic [DATA_W-1:0]  ex_pc,
    output logic [REG_W-1:0]   ex_read1regsel,
    output logic [REG_W-1:0]   ex_read2regsel,
    output logic [REG_W-1:0]   ex_writeregsel,
    output logic               ex_regwrite,
    output logic               ex_memread,
    output logic               ex_memwrite,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic               err
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    import cpu_pkg::*;

    logic               hazard;

    logic               valid_q,    valid_d;
    logic [DATA_W-1:0]  rd1_q,      rd1_d;
    logic [DATA_W-1:0]  rd2_q,      rd2_d;
    logic [DATA_W-1:0]  imm_q,      imm_d;
    logic [DATA_W-1:0]  pc_q,       pc_d;
    logic [REG_W-1:0]   rs1_q,      rs1_d;
    logic [REG_W-1:0]   rs2_q,      rs2_d;
    logic [REG_W-1:0]   wsel_q,     wsel_d;
    logic               regwrite_q, regwrite_d;
    logic               memread_q,  memread_d;
    logic               memwrite_q, memwrite_d;
    logic [ALUOP_W-1:0] aluop_q,    aluop_d;
    logic               err_q,      err_d;

    load_use_detect #(
        .REG_W (REG_W)
    ) u_load_use_detect (
        .id_valid_i       (id_valid),
        .id_read1regsel_i (id_read1regsel),
        .id_read2regsel_i (id_read2regsel),
        .id_use1_i        (id_use1),
        .id_use2_i        (id_use2),
        .ex_valid_i       (valid_q),
        .ex_memread_i     (memread_q),
        .ex_regwrite_i    (regwrite_q),
        .ex_writeregsel_i (wsel_q),
        .hazard_o         (hazard)
    );

    assign id_stall = ex_hold | (hazard & ~flush);

    // Flush beats hold beats bubble beats load; data fields simply hold on flush/bubble.
    always_comb begin
        valid_d    = valid_q;
        rd1_d      = rd1_q;
        rd2_d      = rd2_q;
        imm_d      = imm_q;
        pc_d       = pc_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        wsel_d     = wsel_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        aluop_d    = aluop_q;
        err_d      = err_q;
        if (flush || (!ex_hold && hazard)) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
            err_d      = 1'b0;
        end else if (!ex_hold) begin
            valid_d    = id_valid;
            rd1_d      = id_read1data;
            rd2_d      = id_read2data;
            imm_d      = id_imm;
            pc_d       = id_pc;
            rs1_d      = id_read1regsel;
            rs2_d      = id_read2regsel;
            wsel_d     = id_writeregsel;
            regwrite_d = id_regwrite & id_valid;
            memread_d  = id_memread  & id_valid;
            memwrite_d = id_memwrite & id_valid;
            aluop_d    = id_aluop;
            err_d      = id_valid & id_memread & id_memwrite;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= 1'b0;
            rd1_q      <= '0;
            rd2_q      <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            wsel_q     <= '0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            aluop_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            rd1_q      <= rd1_d;
            rd2_q      <= rd2_d;
            imm_q      <= imm_d;
            pc_q       <= pc_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            wsel_q     <= wsel_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            aluop_q    <= aluop_d;
            err_q      <= err_d;
        end
    end

    assign ex_valid       = valid_q;
    assign ex_read1data   = rd1_q;
    assign ex_read2data   = rd2_q;
    assign ex_imm         = imm_q;
    assign ex_pc          = pc_q;
    assign ex_read1regsel = rs1_q;
    assign ex_read2regsel = rs2_q;
    assign ex_writeregsel = wsel_q;
    assign ex_regwrite    = regwrite_q;
    assign ex_memread     = memread_q;
    assign ex_memwrite    = memwrite_q;
    assign ex_aluop       = aluop_q;
    assign err            = err_q;

`ifdef ID_EX_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Counts only genuine bubble insertions, not cycles where hold or flush masks a hazard.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!flush && !ex_hold && hazard && (stall_cnt_q != STALL_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage; ID_EX_STALL_CNT_EN enables the bubble-counter checks.
module tb_id_ex_stage;

    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;
    localparam int   NV = 25;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [2:0]  id_read1regsel, id_read2regsel;
    logic        id_use1, id_use2;
    logic [15:0] id_read1data, id_read2data, id_imm, id_pc;
    logic [2:0]  id_writeregsel;
    logic        id_regwrite, id_memread, id_memwrite;
    logic [4:0]  id_aluop;
    logic        ex_hold, flush;
    logic        id_stall, ex_valid;
    logic [15:0] ex_read1data, ex_read2data, ex_imm, ex_pc;
    logic [2:0]  ex_read1regsel, ex_read2regsel, ex_writeregsel;
    logic        ex_regwrite, ex_memread, ex_memwrite;
    logic [4:0]  ex_aluop;
    logic        err;
`ifdef ID_EX_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    id_ex_stage #(
        .DATA_W  (16),
        .REG_W   (3),
        .ALUOP_W (5)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_read1regsel (id_read1regsel),
        .id_read2regsel (id_read2regsel),
        .id_use1        (id_use1),
        .id_use2        (id_use2),
        .id_read1data   (id_read1data),
        .id_read2data   (id_read2data),
        .id_imm         (id_imm),
        .id_pc          (id_pc),
        .id_writeregsel (id_writeregsel),
        .id_regwrite    (id_regwrite),
        .id_memread     (id_memread),
        .id_memwrite    (id_memwrite),
        .id_aluop       (id_aluop),
        .ex_hold        (ex_hold),
        .flush          (flush),
        .id_stall       (id_stall),
        .ex_valid       (ex_valid),
        .ex_read1data   (ex_read1data),
        .ex_read2data   (ex_read2data),
        .ex_imm         (ex_imm),
        .ex_pc          (ex_pc),
        .ex_read1regsel (ex_read1regsel),
        .ex_read2regsel (ex_read2regsel),
        .ex_writeregsel (ex_writeregsel),
        .ex_regwrite    (ex_regwrite),
        .ex_memread     (ex_memread),
        .ex_memwrite    (ex_memwrite),
        .ex_aluop       (ex_aluop),
        .err            (err)
`ifdef ID_EX_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs, then expectations; data words are built from tag t as {12,t} {56,t} {9A,t} {BC,t}.
    typedef struct {
        logic       v;
        logic [2:0] r1s, r2s;
        logic       u1, u2;
        logic [2:0] ws;
        logic       rw, mr, mw;
        logic [4:0] op;
        logic       hold, flush;
        logic [7:0] t;
        logic       stall, evalid, erw, emr, emw, eerr, chkd;
        logic [7:0] et;
        logic [4:0] eop;
        logic [2:0] er1s, er2s, ews;
    } vec_t;

    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        id_valid       = v.v;
        id_read1regsel = v.r1s;
        id_read2regsel = v.r2s;
        id_use1        = v.u1;
        id_use2        = v.u2;
        id_writeregsel = v.ws;
        id_regwrite    = v.rw;
        id_memread     = v.mr;
        id_memwrite    = v.mw;
        id_aluop       = v.op;
        ex_hold        = v.hold;
        flush          = v.flush;
        id_read1data   = {8'h12, v.t};
        id_read2data   = {8'h56, v.t};
        id_imm         = {8'h9A, v.t};
        id_pc          = {8'hBC, v.t};
    endtask

    task automatic set_in(input logic v, input logic [2:0] r1s, input logic u1, input logic [2:0] ws,
                          input logic rw, input logic mr, input logic hold, input logic [7:0] t);
        vec_t s;
        s = '{v, r1s, 3'd0, u1, N, ws, rw, mr, N, 5'h00, hold, N, t,
              N, N, N, N, N, N, N, 8'h00, 5'h00, 3'd0, 3'd0, 3'd0};
        apply(s);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{Y,3'd1,3'd4,Y,Y,3'd5,Y,N,N,5'h03,N,N,8'h34, N,Y,Y,N,N,N,Y,8'h34,5'h03,3'd1,3'd4,3'd5};
        vecs[1]  = '{Y,3'd3,3'd3,Y,N,3'd2,Y,Y,N,5'h01,N,N,8'h02, N,Y,Y,Y,N,N,Y,8'h02,5'h01,3'd3,3'd3,3'd2};
        vecs[2]  = '{Y,3'd2,3'd0,Y,N,3'd6,Y,N,N,5'h04,N,N,8'h03, Y,N,N,N,N,N,N,8'h00,5'h00,3'd0,3'd0,3'd0};
        vecs[3]  = '{Y,3'd2,3'd0,Y,N,3'd6,Y,N,N,5'h04,N,N,8'h03, N,Y,Y,N,N,N,Y,8'h03,5'h04,3'd2,3'd0,3'd6};
        vecs[4]  = '{Y,3'd0,3'd0,Y,Y,3'd2,Y,Y,N,5'h01,N,N,8'h05, N,Y,Y,Y,N,N,Y,8'h05,5'h01,3'd0,3'd0,3'd2};
        vecs[5]  = '{Y,3'd2,3'd2,N,N,3'd7,Y,N,N,5'h02,N,N,8'h06, N,Y,Y,N,N,N,Y,8'h06,5'h02,3'd2,3'd2,3'd7};
        vecs[6]  = '{Y,3'd7,3'd1,Y,N,3'd0,Y,Y,N,5'h01,N,N,8'h07, N,Y,Y,Y,N,N,Y,8'h07,5'h01,3'd7,3'd1,3'd0};
        vecs[7]  = '{Y,3'd5,3'd0,Y,Y,3'd3,Y,N,N,5'h02,N,N,8'h08, Y,N,N,N,N,N,N,8'h00,5'h00,3'd0,3'd0,3'd0};
        vecs[8]  = '{Y,3'd5,3'd0,Y,Y,3'd3,Y,N,N,5'h02,N,N,8'h08, N,Y,Y,N,N,N,Y,8'h08,5'h02,3'd5,3'd0,3'd3};
        vecs[9]  = '{Y,3'd3,3'd3,Y,Y,3'd1,N,Y,Y,5'h0A,Y,N,8'h09, Y,Y,Y,N,N,N,Y,8'h08,5'h02,3'd5,3'd0,3'd3};
        vecs[10] = '{Y,3'd6,3'd6,N,N,3'd6,Y,N,N,5'h0B,Y,N,8'h0A, Y,Y,Y,N,N,N,Y,8'h08,5'h02,3'd5,3'd0,3'd3};
        vecs[11] = '{N,3'd4,3'd4,N,N,3'd4,Y,Y,N,5'h0C,Y,N,8'h0B, Y,Y,Y,N,N,N,Y,8'h08,5'h02,3'd5,3'd0,3'd3};
        vecs[12] = '{Y,3'd1,3'd1,N,N,3'd4,N,N,N,5'h06,N,N,8'h0C, N,Y,N,N,N,N,Y,8'h0C,5'h06,3'd1,3'd1,3'd4};
        vecs[13] = '{Y,3'd0,3'd0,N,N,3'd1,Y,Y,Y,5'h07,N,N,8'h0D, N,Y,Y,Y,Y,Y,Y,8'h0D,5'h07,3'd0,3'd0,3'd1};
        vecs[14] = '{Y,3'd1,3'd0,Y,N,3'd2,Y,N,N,5'h08,Y,N,8'h0E, Y,Y,Y,Y,Y,Y,Y,8'h0D,5'h07,3'd0,3'd0,3'd1};
        vecs[15] = '{Y,3'd1,3'd0,Y,N,3'd2,Y,N,N,5'h08,Y,Y,8'h0E, Y,N,N,N,N,N,N,8'h00,5'h00,3'd0,3'd0,3'd0};
        vecs[16] = '{Y,3'd1,3'd0,Y,N,3'd3,Y,N,Y,5'h08,N,N,8'h0F, N,Y,Y,N,Y,N,Y,8'h0F,5'h08,3'd1,3'd0,3'd3};
        vecs[17] = '{Y,3'd3,3'd3,Y,Y,3'd4,Y,Y,N,5'h09,N,Y,8'h10, N,N,N,N,N,N,N,8'h00,5'h00,3'd0,3'd0,3'd0};
        vecs[18] = '{N,3'd2,3'd5,Y,Y,3'd6,Y,Y,Y,5'h0D,N,N,8'h11, N,N,N,N,N,N,Y,8'h11,5'h0D,3'd2,3'd5,3'd6};
        vecs[19] = '{Y,3'd0,3'd0,N,N,3'd5,Y,Y,N,5'h01,N,N,8'h12, N,Y,Y,Y,N,N,Y,8'h12,5'h01,3'd0,3'd0,3'd5};
        vecs[20] = '{Y,3'd5,3'd0,Y,N,3'd1,Y,N,N,5'h02,N,Y,8'h13, N,N,N,N,N,N,N,8'h00,5'h00,3'd0,3'd0,3'd0};
        vecs[21] = '{Y,3'd0,3'd0,N,N,3'd5,Y,Y,N,5'h01,N,N,8'h14, N,Y,Y,Y,N,N,Y,8'h14,5'h01,3'd0,3'd0,3'd5};
        vecs[22] = '{N,3'd5,3'd5,Y,Y,3'd2,Y,N,N,5'h02,N,N,8'h15, N,N,N,N,N,N,Y,8'h15,5'h02,3'd5,3'd5,3'd2};
        vecs[23] = '{Y,3'd0,3'd0,N,N,3'd6,N,Y,N,5'h01,N,N,8'h16, N,Y,N,Y,N,N,Y,8'h16,5'h01,3'd0,3'd0,3'd6};
        vecs[24] = '{Y,3'd6,3'd6,Y,Y,3'd7,Y,N,N,5'h03,N,N,8'h17, N,Y,Y,N,N,N,Y,8'h17,5'h03,3'd6,3'd6,3'd7};

        // Reset with random decode traffic.
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            id_valid       = 1'($urandom);
            id_read1regsel = 3'($urandom);
            id_read2regsel = 3'($urandom);
            id_use1        = 1'($urandom);
            id_use2        = 1'($urandom);
            id_read1data   = 16'($urandom);
            id_read2data   = 16'($urandom);
            id_imm         = 16'($urandom);
            id_pc          = 16'($urandom);
            id_writeregsel = 3'($urandom);
            id_regwrite    = 1'($urandom);
            id_memread     = 1'($urandom);
            id_memwrite    = 1'($urandom);
            id_aluop       = 5'($urandom);
            ex_hold        = 1'b0;
            flush          = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        chk("rst_ex_valid",  32'(ex_valid),       32'(0));
        chk("rst_regwrite",  32'(ex_regwrite),    32'(0));
        chk("rst_memread",   32'(ex_memread),     32'(0));
        chk("rst_memwrite",  32'(ex_memwrite),    32'(0));
        chk("rst_err",       32'(err),            32'(0));
        chk("rst_rd1",       32'(ex_read1data),   32'(0));
        chk("rst_rd2",       32'(ex_read2data),   32'(0));
        chk("rst_imm",       32'(ex_imm),         32'(0));
        chk("rst_pc",        32'(ex_pc),          32'(0));
        chk("rst_aluop",     32'(ex_aluop),       32'(0));
        chk("rst_wsel",      32'(ex_writeregsel), 32'(0));
        chk("rst_rs1",       32'(ex_read1regsel), 32'(0));
        chk("rst_id_stall",  32'(id_stall),       32'(0));
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            #1;
            chk($sformatf("v%0d_id_stall", i), 32'(id_stall), 32'(vecs[i].stall));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ex_valid", i), 32'(ex_valid),    32'(vecs[i].evalid));
            chk($sformatf("v%0d_regwrite", i), 32'(ex_regwrite), 32'(vecs[i].erw));
            chk($sformatf("v%0d_memread", i),  32'(ex_memread),  32'(vecs[i].emr));
            chk($sformatf("v%0d_memwrite", i), 32'(ex_memwrite), 32'(vecs[i].emw));
            chk($sformatf("v%0d_err", i),      32'(err),         32'(vecs[i].eerr));
            if (vecs[i].chkd) begin
                chk($sformatf("v%0d_rd1", i),   32'(ex_read1data),   32'({8'h12, vecs[i].et}));
                chk($sformatf("v%0d_rd2", i),   32'(ex_read2data),   32'({8'h56, vecs[i].et}));
                chk($sformatf("v%0d_imm", i),   32'(ex_imm),         32'({8'h9A, vecs[i].et}));
                chk($sformatf("v%0d_pc", i),    32'(ex_pc),          32'({8'hBC, vecs[i].et}));
                chk($sformatf("v%0d_aluop", i), 32'(ex_aluop),       32'(vecs[i].eop));
                chk($sformatf("v%0d_rs1", i),   32'(ex_read1regsel), 32'(vecs[i].er1s));
                chk($sformatf("v%0d_rs2", i),   32'(ex_read2regsel), 32'(vecs[i].er2s));
                chk($sformatf("v%0d_wsel", i),  32'(ex_writeregsel), 32'(vecs[i].ews));
            end
        end
`ifdef ID_EX_STALL_CNT_EN
        chk("cnt_after_table", 32'(stall_cnt), 32'(2));
`endif

        // Asynchronous reset while a hold and a pending load-use hazard are in flight.
        @(negedge clk);
        set_in(Y, 3'd0, N, 3'd2, Y, Y, N, 8'h20);
        tick();
        set_in(Y, 3'd2, Y, 3'd3, Y, N, Y, 8'h21);
        #1;
        chk("mid_pre_stall", 32'(id_stall), 32'(1));
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid",    32'(ex_valid),     32'(0));
        chk("mid_rst_regwrite", 32'(ex_regwrite),  32'(0));
        chk("mid_rst_memread",  32'(ex_memread),   32'(0));
        chk("mid_rst_rd1",      32'(ex_read1data), 32'(0));
        chk("mid_rst_stall_hold", 32'(id_stall),   32'(1));
        ex_hold = 1'b0;
        #1;
        chk("mid_rst_stall", 32'(id_stall), 32'(0));
`ifdef ID_EX_STALL_CNT_EN
        chk("mid_rst_cnt", 32'(stall_cnt), 32'(0));
`endif
        @(posedge clk);
        #1;
        chk("mid_rst_edge_valid", 32'(ex_valid), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_rst_stall", 32'(id_stall), 32'(0));
        @(posedge clk);
        #1;
        chk("post_rst_valid", 32'(ex_valid),       32'(1));
        chk("post_rst_rs1",   32'(ex_read1regsel), 32'(2));
        chk("post_rst_rd1",   32'(ex_read1data),   32'(16'h1221));
        chk("post_rst_wsel",  32'(ex_writeregsel), 32'(3));
        @(negedge clk);

`ifdef ID_EX_STALL_CNT_EN
        for (int b = 0; b < 5; b++) begin
            set_in(Y, 3'd0, N, 3'd2, Y, Y, N, 8'h30);
            tick();
            set_in(Y, 3'd2, Y, 3'd3, Y, N, N, 8'h31);
            tick();
            tick();
        end
        chk("cnt_five", 32'(stall_cnt), 32'(5));
        set_in(Y, 3'd0, N, 3'd2, Y, Y, N, 8'h32);
        tick();
        set_in(Y, 3'd2, Y, 3'd3, Y, N, Y, 8'h33);
        tick();
        tick();
        chk("cnt_hold_no_count", 32'(stall_cnt), 32'(5));
        ex_hold = 1'b0;
        tick();
        chk("cnt_after_release", 32'(stall_cnt), 32'(6));
        tick();
        set_in(Y, 3'd0, N, 3'd2, Y, Y, N, 8'h34);
        tick();
        force dut.stall_cnt_q = 16'hFFFF;
        #1;
        release dut.stall_cnt_q;
        #1;
        chk("cnt_forced", 32'(stall_cnt), 32'(16'hFFFF));
        set_in(Y, 3'd2, Y, 3'd3, Y, N, N, 8'h35);
        #1;
        chk("cnt_sat_stall", 32'(id_stall), 32'(1));
        tick();
        chk("cnt_saturated", 32'(stall_cnt), 32'(16'hFFFF));
        chk("cnt_sat_bubble", 32'(ex_valid), 32'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register for the 16-bit pipelined core.
- Captures the register-file read data (with write-bypass already applied), immediate, PC and control bits from decode.
- Detects load-use hazards against the instruction in EX and inserts a bubble.
- Honours a downstream hold and a branch flush. Its outputs feed the execute stage and the forwarding muxes.

Parameters:
- DATA_W, 16, width of register data, immediate and PC.
- REG_W, 3, width of register selectors.
- ALUOP_W, 5, width of the ALU operation code.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous assert, active-low.
- id_valid  input  1  decode holds a real instruction.
- id_read1regsel, id_read2regsel  input  REG_W  source selectors.
- id_use1, id_use2  input  1  the instruction actually reads source 1 / source 2.
- id_read1data, id_read2data  input  DATA_W  bypassed register data.
- id_imm, id_pc  input  DATA_W  sign-extended immediate; PC+2.
- id_writeregsel  input  REG_W  destination register.
- id_regwrite, id_memread, id_memwrite  input  1  control bits.
- id_aluop  input  ALUOP_W  ALU operation.
- ex_hold  input  1  downstream cannot accept; freeze stage.
- flush  input  1  branch/jump taken in EX; squash.
- id_stall  output  1  combinational; decode and fetch must hold.
- ex_valid  output  1  EX instruction is real.
- ex_read1data, ex_read2data, ex_imm, ex_pc  output  DATA_W  registered copies.
- ex_read1regsel, ex_read2regsel, ex_writeregsel  output  REG_W  registered copies.
- ex_regwrite, ex_memread, ex_memwrite  output  1  registered; forced 0 when ex_valid=0.
- ex_aluop  output  ALUOP_W  registered.
- err  output  1  registered; illegal control combination captured.

Behaviour:
- Reset (rst=0, asynchronous): every output register goes to 0; ex_valid=0, err=0.
- Hazard condition: hazard = id_valid & ex_valid & ex_memread & ex_regwrite & ((id_use1 & id_read1regsel==ex_writeregsel) | (id_use2 & id_read2regsel==ex_writeregsel)).
- Stall output: id_stall = ex_hold | (hazard & ~flush).
- Per-cycle update, highest priority first:
  1. flush=1: ex_valid<=0 and control bits<=0, even if ex_hold=1. The data fields may hold or load.
  2. ex_hold=1: every register holds its value.
  3. hazard=1: a bubble is loaded. ex_valid<=0, ex_regwrite/ex_memread/ex_memwrite<=0; data fields are don't-care.
  4. Otherwise all fields load from decode: ex_valid<=id_valid, control bits<=id_* & id_valid.
- Latency: 1 cycle from decode to EX.
- A load-use pair costs exactly 1 bubble. In the next cycle ex_valid=0, so hazard deasserts and the consumer advances. MEM->EX forwarding downstream covers the rest.
- Register 0 is a real register: no special-case suppression on selector matches.
- err: on a load cycle (case 4), err<=id_valid & id_memread & id_memwrite. It holds under ex_hold. It clears on flush or bubble.
- Reset mid-operation: takes effect immediately and discards any in-flight hold or bubble.
- With ex_hold and hazard both asserted, the stage only holds. The hazard is re-evaluated when the hold releases.

Optional Feature:
- Macro ID_EX_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt, 16 bits.
  - Saturating count of cycles in which a hazard bubble was inserted (case 3). It stops at 16'hFFFF.
  - Reset to 0 by rst.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package cpu_pkg holds the DATA_W/REG_W/ALUOP_W constants and the ALU-op encoding constants used by decode and execute.
- One sub-module, load_use_detect: purely combinational. Inputs are the ID selectors/use bits and the EX writeregsel/memread/regwrite/valid; output is hazard.
- The pipeline register itself stays in id_ex_stage.

Test Plan:
- Reset: hold rst=0 with random inputs -> all ex_* outputs=0, err=0, id_stall=0. Release rst, then id_valid=1, id_aluop=5'h03, id_read1data=16'h1234 -> next edge ex_valid=1, ex_aluop=5'h03, ex_read1data=16'h1234.
- Load-use:
  - EX holds a load (ex_memread=1, ex_regwrite=1, ex_writeregsel=3'd2); ID has id_use1=1, id_read1regsel=3'd2.
  - Expect id_stall=1 that cycle and ex_valid=0 after the edge.
  - The following cycle expects id_stall=0, and the consumer loads with ex_read1regsel=3'd2.
- No false hazard: same load with id_use1=0 and id_use2=0 (regsel 3'd2), or with a non-load producer -> id_stall=0, no bubble.
- Hold: ex_hold=1 for 3 cycles with changing id_* inputs -> ex_* outputs constant and id_stall=1. On release they load the current decode values.
- Flush priority: flush=1 together with ex_hold=1 and a hazard -> ex_valid=0, ex_regwrite=0, ex_memwrite=0, and id_stall=1 (due to the hold) in that cycle.
- err, plus the counter when ID_EX_STALL_CNT_EN is defined:
  - id_memread=1 with id_memwrite=1 -> err=1 next edge.
  - Five load-use bubbles -> stall_cnt=5.
  - Force the counter to 16'hFFFF, then one more bubble -> it stays at 16'hFFFF.
